seq2_responder: RTL and testbench
=================================

SEQ2_RESPONDER -- requirements
Module: seq2_responder

Interface
REQ-001 Parameter DEPTH, default 4, is the number of outstanding accepted transactions; legal range is 2..8.
REQ-002 Parameter D_DELAY, default 3, is the nominal number of cycles from c to d; legal range is 2..10.
REQ-003 Parameter AB_MAX, default 5, is the last cycle after rose(a) in which b is accepted.
REQ-004 clk  in  1  the single clock; all logic is on posedge.
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 a  in  1  request start; a rising edge opens an attempt.
REQ-007 b  in  1  request qualifier, sampled in the window.
REQ-008 d_stall  in  1  back-pressure; holds off d issue.
REQ-009 c  out  1  acknowledge pulse, one cycle wide.
REQ-010 d  out  1  completion pulse, one cycle wide.
REQ-011 d_tag  out  8  tag of the transaction completing; valid while d=1, otherwise 0.
REQ-012 an_tag  out  8  count of accepted antecedents; wraps modulo 256.
REQ-013 co_tag  out  8  count of issued completions; wraps modulo 256.
REQ-014 late_err  out  1  sticky flag: a d was issued more than 10 cycles after its c.
REQ-015 ovf_err  out  1  sticky flag: an antecedent was dropped because the FIFO was full.

Function
REQ-016 rose(a) is a=1 in the current cycle and a=0 registered from the previous cycle.
REQ-017 Window FSM states: IDLE and ARMED. rose(a) in IDLE moves the FSM to ARMED with win_cnt=1.
REQ-018 In ARMED, win_cnt increments each cycle. b=1 with 1<=win_cnt<=AB_MAX accepts the attempt, and the FSM returns to IDLE.
REQ-019 Only the first b in a window is accepted (first-match behaviour).
REQ-020 If win_cnt exceeds AB_MAX without b, the attempt is dropped silently and the FSM returns to IDLE.
REQ-021 rose(a) while ARMED is ignored. The window does not restart.
REQ-022 b in the same cycle as rose(a) is not accepted; the earliest acceptable b is one cycle later.
REQ-023 On accept with the FIFO not full: push {tag=an_tag, ts=cyc}, increment an_tag, and pulse c in the next cycle.
REQ-024 On accept with the FIFO full: no push, no c, an_tag unchanged, ovf_err set.
REQ-025 cyc is an 8-bit free-running counter. Entry age = (cyc - ts) mod 256, where ts is the cycle in which c is high.
REQ-026 d issues when the FIFO is non-empty, head age >= D_DELAY, and d_stall=0.
REQ-027 On d issue: d=1, d_tag=head tag, pop the head, and increment co_tag, all in the same cycle.
REQ-028 At most one d is issued per cycle, and completions are strictly in order (d_tag equals co_tag before the increment).
REQ-029 An issue with head age > 10 still completes normally and also sets late_err.
REQ-030 Push and pop in the same cycle are both honoured. Full is judged before the pop.
REQ-031 An accept, a c pulse and a d issue may all occur in the same cycle.

Reset
REQ-032 While rst_n=0 at posedge: FSM goes to IDLE; win_cnt, cyc, an_tag, co_tag are 0; FIFO is empty; c, d, d_tag are 0; late_err and ovf_err are 0.
REQ-033 Reset mid-transaction discards all outstanding entries and pending c pulses. No d is issued for them after reset.
REQ-034 The sticky flags clear only by reset.

Structure
REQ-035 Package seq2_resp_pkg holds: TAG_W=8, TS_W=8, D_MAX=10, the FSM state enum, and the FIFO entry struct {tag, ts}.
REQ-036 Sub-module seq2_resp_fifo is a synchronous DEPTH-entry FIFO of entries, with full/empty outputs and the same clk/rst_n.
REQ-037 All outputs are registered.

Verification
REQ-038 rose(a) at cycle 0, b at cycle 3 -> c=1 at cycle 4, d=1 with d_tag=0 at cycle 7, an_tag=co_tag=1.
REQ-039 rose(a) at cycle 0, b only at cycle 6 -> no c, no d, an_tag stays 0.
REQ-040 Five back-to-back accepts (a pulsing, b at +1) with d_stall=1 -> four c pulses, fifth dropped, ovf_err=1, an_tag=4.
REQ-041 One accept, d_stall held for 12 cycles after c -> d issues at age 12 with d_tag=0, late_err=1.
REQ-042 Two accepts 2 cycles apart, d_stall=0 -> d pulses D_DELAY after each c, d_tag 0 then 1, in order.
REQ-043 rst_n low for 1 cycle between c and d -> no d follows; all counters and flags read 0.

Source files
------------

// File: rtl/seq2_resp_pkg.sv
// Shared types and constants for the seq2 responder.
// Holds widths, the late-completion limit, window FSM states and FIFO entries.
package seq2_resp_pkg;

    localparam int TAG_W = 8;
    localparam int TS_W  = 8;
    localparam int D_MAX = 10;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ARMED = 1'b1
    } win_state_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [TS_W-1:0]  ts;
    } fifo_ent_t;

endpackage

// File: rtl/seq2_resp_fifo.sv
// Synchronous FIFO of {tag, ts} entries for outstanding transactions.
// Ports: clk, rst_n (sync, active-low), push/din, pop/head, full, empty.
module seq2_resp_fifo
    import seq2_resp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  fifo_ent_t din,
    input  logic      pop,
    output fifo_ent_t head,
    output logic      full,
    output logic      empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fifo_ent_t mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic do_push;
    logic do_pop;

    // Full is judged on the pre-pop occupancy, so a push into a full
    // FIFO is refused even when the head leaves in the same cycle.
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/seq2_responder.sv
// Request/acknowledge/completion responder: a rising a opens a b window,
// accepted requests get a c pulse, and complete in order with d after D_DELAY.
// Ports: clk, rst_n (sync, active-low), a, b, d_stall in; c, d, d_tag,
// an_tag, co_tag, late_err, ovf_err out (all registered).
module seq2_responder
    import seq2_resp_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int D_DELAY = 3,
    parameter int AB_MAX  = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a,
    input  logic       b,
    input  logic       d_stall,
    output logic       c,
    output logic       d,
    output logic [7:0] d_tag,
    output logic [7:0] an_tag,
    output logic [7:0] co_tag,
    output logic       late_err,
    output logic       ovf_err
);

    localparam logic [7:0] WIN_LIM = 8'(AB_MAX);
    localparam logic [7:0] DLY     = 8'(D_DELAY);
    localparam logic [7:0] LATE    = 8'(D_MAX);

    win_state_t state;
    win_state_t state_nxt;
    logic [7:0] win_cnt;
    logic [7:0] win_nxt;
    logic       a_q;
    logic       rose;
    logic       accept;
    logic [7:0] cyc;
    logic [7:0] cyc_nxt;
    logic [7:0] age_nxt;
    logic       push;
    logic       issue;
    logic       full;
    logic       empty;
    fifo_ent_t  din;
    fifo_ent_t  head;

    assign rose = a && !a_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            win_cnt <= '0;
        end else begin
            state   <= state_nxt;
            win_cnt <= win_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        win_nxt   = win_cnt;
        accept    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (rose) begin
                    state_nxt = S_ARMED;
                    win_nxt   = 8'd1;
                end
            end
            S_ARMED: begin
                // A second rise of a while armed does not restart the window.
                if (b && win_cnt >= 8'd1 && win_cnt <= WIN_LIM) begin
                    accept    = 1'b1;
                    state_nxt = S_IDLE;
                    win_nxt   = '0;
                end else if (win_cnt >= WIN_LIM) begin
                    state_nxt = S_IDLE;
                    win_nxt   = '0;
                end else begin
                    win_nxt = win_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                win_nxt   = '0;
            end
        endcase
    end

    // The entry timestamp is the cycle in which c is high, which is the
    // cycle after the push, hence cyc + 1.
    assign cyc_nxt = cyc + 8'd1;
    assign push    = accept && !full;
    assign din     = '{tag: an_tag, ts: cyc_nxt};

    // d is registered, so the issue decision uses the age the head will
    // have in the cycle where d is actually high.
    assign age_nxt = cyc_nxt - head.ts;
    assign issue   = !empty && (age_nxt >= DLY) && !d_stall;

    seq2_resp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (din),
        .pop   (issue),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q      <= 1'b0;
            cyc      <= '0;
            c        <= 1'b0;
            d        <= 1'b0;
            d_tag    <= '0;
            an_tag   <= '0;
            co_tag   <= '0;
            late_err <= 1'b0;
            ovf_err  <= 1'b0;
        end else begin
            a_q   <= a;
            cyc   <= cyc_nxt;
            c     <= push;
            d     <= issue;
            d_tag <= issue ? head.tag : '0;
            if (push) begin
                an_tag <= an_tag + 8'd1;
            end
            if (issue) begin
                co_tag <= co_tag + 8'd1;
            end
            if (issue && age_nxt > LATE) begin
                late_err <= 1'b1;
            end
            if (accept && full) begin
                ovf_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq2_responder.sv
// Directed scoreboard bench for seq2_responder: expected c cycles and
// d {tag, cycle} are queued as stimulus is driven and popped on output.
module tb_seq2_responder;

    logic       clk;
    logic       rst_n;
    logic       a;
    logic       b;
    logic       d_stall;
    logic       c;
    logic       d;
    logic [7:0] d_tag;
    logic [7:0] an_tag;
    logic [7:0] co_tag;
    logic       late_err;
    logic       ovf_err;

    typedef struct {
        int tag;
        int cyc;
    } dexp_t;

    int    cq[$];
    dexp_t dq[$];
    int    now;
    int    n_cmp;
    int    n_err;
    int    t;
    int    ec;
    dexp_t ed;

    seq2_responder #(
        .DEPTH   (4),
        .D_DELAY (3),
        .AB_MAX  (5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .d_stall  (d_stall),
        .c        (c),
        .d        (d),
        .d_tag    (d_tag),
        .an_tag   (an_tag),
        .co_tag   (co_tag),
        .late_err (late_err),
        .ovf_err  (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial now = 0;
    always @(posedge clk) now <= now + 1;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Output monitor: every c and d pulse must match the queue head.
    always @(negedge clk) begin
        if (c === 1'b1) begin
            ec = (cq.size() > 0) ? cq.pop_front() : -1;
            chk("c_cycle", now, ec);
        end
        if (d === 1'b1) begin
            if (dq.size() > 0) begin
                ed = dq.pop_front();
            end else begin
                ed.tag = -1;
                ed.cyc = -1;
            end
            chk("d_cycle", now, ed.cyc);
            chk("d_tag", {24'd0, d_tag}, ed.tag);
        end else begin
            chk("d_tag_idle", {24'd0, d_tag}, 0);
        end
    end

    task automatic go(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_c(int cy);
        cq.push_back(cy);
    endtask

    task automatic exp_d(int tag, int cy);
        dexp_t e;
        e.tag = tag;
        e.cyc = cy;
        dq.push_back(e);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        a       = 1'b0;
        b       = 1'b0;
        d_stall = 1'b0;
        go(2);
        rst_n = 1'b1;
    endtask

    task automatic end_chk(string nm, int an, int co, int lt, int ov);
        chk({nm, "_cq_left"}, cq.size(), 0);
        chk({nm, "_dq_left"}, dq.size(), 0);
        chk({nm, "_an_tag"}, {24'd0, an_tag}, an);
        chk({nm, "_co_tag"}, {24'd0, co_tag}, co);
        chk({nm, "_late"}, {31'd0, late_err}, lt);
        chk({nm, "_ovf"}, {31'd0, ovf_err}, ov);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        a = 1'b0;
        b = 1'b0;
        d_stall = 1'b0;

        // Reset state
        do_reset();
        chk("rst_c", {31'd0, c}, 0);
        chk("rst_d", {31'd0, d}, 0);
        end_chk("rst", 0, 0, 0, 0);

        // Basic: b three cycles after rise
        t = now;
        a = 1'b1;
        go(1);
        a = 1'b0;
        go(2);
        b = 1'b1;
        exp_c(t + 4);
        exp_d(0, t + 7);
        go(1);
        b = 1'b0;
        go(6);
        end_chk("basic", 1, 1, 0, 0);

        // Window boundaries
        do_reset();
        go(1);
        t = now;
        a = 1'b1;
        go(1);
        a = 1'b0;
        go(5);
        b = 1'b1;
        go(1);
        b = 1'b0;
        go(3);
        chk("late_b_an_tag", {24'd0, an_tag}, 0);

        t = now;
        a = 1'b1;
        b = 1'b1;
        go(1);
        a = 1'b0;
        b = 1'b0;
        go(1);
        b = 1'b1;
        exp_c(t + 3);
        exp_d(0, t + 6);
        go(2);
        b = 1'b0;
        go(5);
        chk("first_match_an", {24'd0, an_tag}, 1);

        t = now;
        a = 1'b1;
        go(1);
        a = 1'b0;
        go(1);
        a = 1'b1;
        go(1);
        a = 1'b0;
        go(3);
        b = 1'b1;
        go(1);
        b = 1'b0;
        go(3);
        chk("no_restart_an", {24'd0, an_tag}, 1);

        t = now;
        a = 1'b1;
        go(1);
        a = 1'b0;
        go(4);
        b = 1'b1;
        exp_c(t + 6);
        exp_d(1, t + 9);
        go(1);
        b = 1'b0;
        go(4);
        end_chk("window", 2, 2, 0, 0);

        // Overflow: five accepts under stall, depth 4
        do_reset();
        go(1);
        d_stall = 1'b1;
        t = now;
        for (int i = 0; i < 5; i++) begin
            a = 1'b1;
            b = 1'b0;
            go(1);
            a = 1'b0;
            b = 1'b1;
            if (i < 4) begin
                exp_c(t + 2 * i + 2);
                exp_d(i, t + 11 + i);
            end
            if (i < 4) go(1);
        end
        go(1);
        b = 1'b0;
        d_stall = 1'b0;
        chk("ovf_an_tag", {24'd0, an_tag}, 4);
        go(6);
        end_chk("ovf", 4, 4, 0, 1);

        // Completion at age exactly 10 is not late
        do_reset();
        go(1);
        d_stall = 1'b1;
        t = now;
        a = 1'b1;
        go(1);
        a = 1'b0;
        b = 1'b1;
        exp_c(t + 2);
        exp_d(0, t + 12);
        go(1);
        b = 1'b0;
        go(9);
        d_stall = 1'b0;
        go(3);
        end_chk("age10", 1, 1, 0, 0);

        // Completion at age 12 sets late_err
        do_reset();
        go(1);
        d_stall = 1'b1;
        t = now;
        a = 1'b1;
        go(1);
        a = 1'b0;
        b = 1'b1;
        exp_c(t + 2);
        exp_d(0, t + 14);
        go(1);
        b = 1'b0;
        go(11);
        d_stall = 1'b0;
        go(3);
        end_chk("age12", 1, 1, 1, 0);

        // Reset between c and d drops the pending completion
        t = now;
        a = 1'b1;
        go(1);
        a = 1'b0;
        b = 1'b1;
        exp_c(t + 2);
        go(1);
        b = 1'b0;
        go(1);
        rst_n = 1'b0;
        go(1);
        rst_n = 1'b1;
        chk("mid_rst_c", {31'd0, c}, 0);
        go(8);
        end_chk("mid_rst", 0, 0, 0, 0);

        // Two accepts two cycles apart complete in order
        t = now;
        a = 1'b1;
        go(1);
        a = 1'b0;
        b = 1'b1;
        exp_c(t + 2);
        exp_d(0, t + 5);
        go(1);
        a = 1'b1;
        b = 1'b0;
        go(1);
        a = 1'b0;
        b = 1'b1;
        exp_c(t + 4);
        exp_d(1, t + 7);
        go(1);
        b = 1'b0;
        go(6);
        end_chk("pair", 2, 2, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
